// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg
// Shared definitions for the sequential shift-add multiplier:
//   - state_t       : controller states (IDLE / BUSY / DONE)
//   - DEFAULT_WIDTH : default operand width used by seq_mult
package seq_mult_pkg;

    localparam int DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_addstep.sv
// seq_mult_addstep
// One shift-add datapath step: a (WIDTH+1)-bit add of two WIDTH-bit values,
// where the top bit of the result is the carry-out.
// Ports:
//   i_a   [WIDTH-1:0] : upper accumulator half
//   i_b   [WIDTH-1:0] : multiplicand, or zero when the multiplier LSB is 0
//   o_sum [WIDTH:0]   : {carry, sum}
module seq_mult_addstep #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_sum
);

    assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/seq_mult.sv
// seq_mult
// Sequential shift-add multiplier, one partial product per clock. Signed
// operands are converted to magnitudes on acceptance, and the result sign is
// applied when the product is loaded. Latency is always WIDTH cycles.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (in_ready only in IDLE)
//   A, B [WIDTH-1:0]      : multiplicand, multiplier
//   signed_mode           : 1 = two's complement operands, 0 = unsigned
//   out_valid / out_ready : result handshake (out_valid held in DONE)
//   product [2*WIDTH-1:0] : result
//   busy                  : high while in BUSY
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mult;
    logic [WIDTH-1:0]     r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_sign;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_next_acc;
    logic [WIDTH-1:0]     w_next_mult;
    logic [2*WIDTH-1:0]   w_mag;
    logic [2*WIDTH-1:0]   w_final;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_last_step;

    // Negating the most negative value yields 2^(WIDTH-1), which is exactly
    // the magnitude wanted when read back as unsigned.
    assign w_a_mag = (signed_mode && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign w_b_mag = (signed_mode && B[WIDTH-1]) ? (~B + 1'b1) : B;

    assign w_addend = r_mult[0] ? r_mcand : '0;

    seq_mult_addstep #(.WIDTH(WIDTH)) u_addstep (
        .i_a   (r_acc),
        .i_b   (w_addend),
        .o_sum (w_sum)
    );

    // {carry, acc, mult} shifted right by one: the sum LSB drops into the
    // multiplier register, which fills with low product bits as it empties.
    assign w_next_acc  = w_sum[WIDTH:1];
    assign w_next_mult = {w_sum[0], r_mult[WIDTH-1:1]};
    assign w_mag       = {w_next_acc, w_next_mult};
    assign w_final     = r_sign ? (~w_mag + 1'b1) : w_mag;
    assign w_last_step = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mcand     <= '0;
            r_mult      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_product   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= BUSY;
                        r_mcand    <= w_a_mag;
                        r_mult     <= w_b_mag;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_sign     <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    r_acc  <= w_next_acc;
                    r_mult <= w_next_mult;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last_step) begin
                        r_state     <= DONE;
                        r_product   <= w_final;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_product;

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the operand width; legal values are 4..128.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: operands and mode are presented.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have port A, input, WIDTH bits: multiplicand.
REQ-007 SHALL have port B, input, WIDTH bits: multiplier.
REQ-008 SHALL have port signed_mode, input, 1 bit: 1 treats A and B as two's complement; 0 treats them as unsigned.
REQ-009 SHALL have port out_valid, output, 1 bit: the product is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-011 SHALL have port product, output, 2*WIDTH bits: result.
REQ-012 SHALL have port busy, output, 1 bit: high while a multiplication is in progress (BUSY state).

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; acceptance occurs on a rising edge where in_valid&&in_ready, and A, B and signed_mode are captured on that edge.
REQ-015 On acceptance, SHALL move IDLE->BUSY, clear the accumulator and bit counter, and store operand magnitudes: in signed_mode, negate a negative operand; -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits WIDTH unsigned bits.
REQ-016 SHALL latch result sign = A[WIDTH-1]^B[WIDTH-1] when signed_mode=1, else 0.
REQ-017 SHALL run one shift-add step per BUSY cycle: if the multiplier LSB is 1, add the multiplicand to the upper accumulator half through a WIDTH+1-bit adder, keeping the carry; then shift {carry,acc,mult} right by one.
REQ-018 SHALL spend exactly WIDTH cycles in BUSY; on the WIDTH-th BUSY edge, move to DONE and load product (negated to two's complement if the sign is 1).
REQ-019 out_valid SHALL rise exactly WIDTH clock cycles after the accepting edge, and latency SHALL be independent of operand values.
REQ-020 In DONE, SHALL hold out_valid=1 and product stable until an edge with out_ready=1, then move DONE->IDLE.
REQ-021 A new operand SHALL be accepted no earlier than the cycle after the product handshake (in_ready=0 in DONE); no back-to-back overlap.
REQ-022 in_valid during BUSY or DONE SHALL be ignored, and operands changing after acceptance SHALL not affect the result.
REQ-023 product SHALL be bit-exact: unsigned A*B (mod 2^(2*WIDTH)) or signed A*B as a 2*WIDTH-bit two's complement value.
REQ-024 Zero operands SHALL still take the full WIDTH cycles.

Reset
REQ-025 When rst=1 at a rising edge, SHALL enter IDLE regardless of state, including mid-BUSY or in DONE, and discard any in-progress result without producing it.
REQ-026 Reset values SHALL be: in_ready=1 after the reset edge, out_valid=0, busy=0, product=0, counter=0, accumulator=0.
REQ-027 rst SHALL take priority over every handshake on the same edge.

Structure
REQ-028 Package seq_mult_pkg SHALL hold the FSM state enum (IDLE/BUSY/DONE) and the default WIDTH constant.
REQ-029 SHALL instantiate one sub-module, seq_mult_addstep, containing the parametrised (WIDTH+1)-bit add with carry-out; all other logic stays in seq_mult.
REQ-030 The counter width SHALL be $clog2(WIDTH+1) bits.

Verification
REQ-031 SHALL cover WIDTH=64 unsigned with A=0xFFFFFFFFFFFFFFFF, B=0xFFFFFFFFFFFFFFFF -> product=0xFFFFFFFFFFFFFFFE0000000000000001, out_valid 64 cycles after acceptance.
REQ-032 SHALL cover WIDTH=8 signed with A=0x80 (-128), B=0x80 -> product=0x4000; and A=0x80, B=0x01 -> product=0xFF80.
REQ-033 SHALL cover WIDTH=8 unsigned with A=0x80, B=0xFF -> product=0x7F80; the same operands with signed_mode=1 -> product=0x0080.
REQ-034 SHALL cover out_ready held 0 for 10 cycles in DONE -> product and out_valid stable and in_ready=0 throughout; release -> IDLE, in_ready=1 the next cycle.
REQ-035 SHALL cover rst pulsed at BUSY cycle 30 (WIDTH=64) -> next cycle IDLE, out_valid=0, product=0; a following A=3, B=5 -> product=15 at +64 cycles.
REQ-036 SHALL cover operands changed and in_valid toggled during BUSY -> result equals the originally accepted operands.
